// File: rtl/matrix_ctrl_fsm.sv
// Top-level sequencer for the matrix calculator: state, latched operation and datapath start pulses.
// Optional S9 timeout enabled by defining MATRIX_WAIT_TIMEOUT_EN.
module matrix_ctrl_fsm #(
    parameter int unsigned CLK_HZ   = 100_000_000,
    parameter int unsigned WAIT_SEC = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_confirm,
    input  logic       btn_back,
    input  logic [2:0] sw_mode,
    input  logic [3:0] sw_op,
    input  logic       input_done,
    input  logic       gen_done,
    input  logic       store_done,
    input  logic       compute_done,
    input  logic       dim_err,
    output logic [3:0] state,
    output logic [3:0] op_type,
    output logic       input_start,
    output logic       gen_start,
    output logic       store_start,
    output logic       compute_start
);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_MENU    = 4'd1,
        S_INPUT   = 4'd2,
        S_GEN     = 4'd3,
        S_DISPLAY = 4'd4,
        S_COMPUTE = 4'd5,
        S_ERROR   = 4'd6,
        S_STORE   = 4'd7,
        S_SELECT  = 4'd8,
        S_WAIT    = 4'd9
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] op_q, op_d;
    logic       op_onehot_c;
    logic       timeout_c;

`ifdef MATRIX_WAIT_TIMEOUT_EN
    localparam int unsigned WAIT_CYCLES = CLK_HZ * WAIT_SEC;
    localparam int unsigned TIMER_W     = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    logic [TIMER_W-1:0] timer_q;

    assign timeout_c = (timer_q == TIMER_W'(WAIT_CYCLES - 1));

    // Dwell counter: runs only while staying in S9, zero everywhere else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_q <= '0;
        end else if (state_q == S_WAIT && state_d == S_WAIT) begin
            timer_q <= timer_q + TIMER_W'(1);
        end else begin
            timer_q <= '0;
        end
    end
`else
    assign timeout_c = 1'b0;
`endif

    assign op_onehot_c = (sw_op != 4'd0) && ((sw_op & (sw_op - 4'd1)) == 4'd0);

    // Next-state and operation latch
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        case (state_q)
            S_IDLE: begin
                if (btn_confirm) state_d = S_MENU;
            end
            S_MENU: begin
                if (btn_back) begin
                    state_d = S_IDLE;
                end else if (btn_confirm) begin
                    case (sw_mode)
                        3'b001:  state_d = S_INPUT;
                        3'b010:  state_d = S_GEN;
                        3'b100:  state_d = S_SELECT;
                        default: state_d = S_ERROR;
                    endcase
                end
            end
            S_INPUT: begin
                if (btn_back)        state_d = S_MENU;
                else if (input_done) state_d = S_STORE;
            end
            S_GEN: begin
                if (gen_done) state_d = S_STORE;
            end
            S_STORE: begin
                if (store_done) state_d = S_DISPLAY;
            end
            S_DISPLAY, S_ERROR: begin
                if (btn_confirm || btn_back) state_d = S_MENU;
            end
            S_SELECT: begin
                if (btn_back) begin
                    state_d = S_MENU;
                end else if (btn_confirm) begin
                    if (op_onehot_c) begin
                        op_d    = sw_op;
                        state_d = S_COMPUTE;
                    end else begin
                        state_d = S_ERROR;
                    end
                end
            end
            S_COMPUTE: begin
                if (dim_err)           state_d = S_WAIT;
                else if (compute_done) state_d = S_DISPLAY;
            end
            S_WAIT: begin
                if (btn_back)         state_d = S_MENU;
                else if (btn_confirm) state_d = S_SELECT;
                else if (timeout_c)   state_d = S_MENU;
            end
            default: state_d = S_IDLE;
        endcase
        if (state_d == S_IDLE) op_d = 4'd0;
    end

    // State, operation and entry-only start pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            op_q          <= 4'd0;
            input_start   <= 1'b0;
            gen_start     <= 1'b0;
            store_start   <= 1'b0;
            compute_start <= 1'b0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            input_start   <= (state_d == S_INPUT)   && (state_q != S_INPUT);
            gen_start     <= (state_d == S_GEN)     && (state_q != S_GEN);
            store_start   <= (state_d == S_STORE)   && (state_q != S_STORE);
            compute_start <= (state_d == S_COMPUTE) && (state_q != S_COMPUTE);
        end
    end

    assign state   = state_q;
    assign op_type = op_q;

endmodule

// File: tb/tb_matrix_ctrl_fsm.sv
// Scoreboard bench for matrix_ctrl_fsm: stimulus queues expected outputs per edge, a monitor checks them.
module tb_matrix_ctrl_fsm;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_confirm = 1'b0;
    logic       btn_back = 1'b0;
    logic [2:0] sw_mode = 3'b000;
    logic [3:0] sw_op = 4'b0000;
    logic       input_done = 1'b0;
    logic       gen_done = 1'b0;
    logic       store_done = 1'b0;
    logic       compute_done = 1'b0;
    logic       dim_err = 1'b0;
    logic [3:0] state;
    logic [3:0] op_type;
    logic       input_start, gen_start, store_start, compute_start;

    matrix_ctrl_fsm #(.CLK_HZ(10), .WAIT_SEC(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .btn_confirm(btn_confirm), .btn_back(btn_back),
        .sw_mode(sw_mode), .sw_op(sw_op),
        .input_done(input_done), .gen_done(gen_done),
        .store_done(store_done), .compute_done(compute_done),
        .dim_err(dim_err),
        .state(state), .op_type(op_type),
        .input_start(input_start), .gen_start(gen_start),
        .store_start(store_start), .compute_start(compute_start)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         tag;
        logic [3:0] st;
        logic [3:0] op;
        logic [3:0] strt;
        string      nm;
    } exp_t;

    exp_t       exp_q[$];
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    logic [3:0] eop = 4'd0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compares the outputs after each edge against the item tagged for that edge
    always @(posedge clk) begin
        #2;
        if (exp_q.size() > 0) begin
            exp_t e;
            logic [3:0] act_strt;
            e = exp_q[0];
            act_strt = {input_start, gen_start, store_start, compute_start};
            if (e.tag < cyc) begin
                void'(exp_q.pop_front());
                checks++;
                errors++;
                $display("FAIL %s: expectation for edge %0d never checked (now %0d)", e.nm, e.tag, cyc);
            end else if (e.tag == cyc) begin
                void'(exp_q.pop_front());
                checks++;
                if (state !== e.st || op_type !== e.op || act_strt !== e.strt) begin
                    errors++;
                    $display("FAIL %s: got state=%0d op=%b starts=%b, want state=%0d op=%b starts=%b",
                             e.nm, state, op_type, act_strt, e.st, e.op, e.strt);
                end
            end
        end
    end

    task automatic direct_check(input string nm, input logic [3:0] st_w, input logic [3:0] op_w);
        checks++;
        if (state !== st_w || op_type !== op_w ||
            {input_start, gen_start, store_start, compute_start} !== 4'b0000) begin
            errors++;
            $display("FAIL %s: got state=%0d op=%b starts=%b, want state=%0d op=%b starts=0000",
                     nm, state, op_type, {input_start, gen_start, store_start, compute_start},
                     st_w, op_w);
        end
    endtask

    // One edge of stimulus; starts encoded {input,gen,store,compute}
    task automatic ev(input string what, input logic [3:0] est, input logic [3:0] estrt,
                      input string nm);
        exp_t e;
        @(negedge clk);
        case (what)
            "c":  btn_confirm = 1'b1;
            "b":  btn_back = 1'b1;
            "cb": begin btn_confirm = 1'b1; btn_back = 1'b1; end
            "id": input_done = 1'b1;
            "gd": gen_done = 1'b1;
            "sd": store_done = 1'b1;
            "cd": compute_done = 1'b1;
            "de": dim_err = 1'b1;
            "dc": begin dim_err = 1'b1; compute_done = 1'b1; end
            default: ;
        endcase
        e.tag  = cyc + 1;
        e.st   = est;
        e.op   = eop;
        e.strt = estrt;
        e.nm   = nm;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        btn_confirm = 1'b0; btn_back = 1'b0;
        input_done = 1'b0; gen_done = 1'b0; store_done = 1'b0;
        compute_done = 1'b0; dim_err = 1'b0;
    endtask

    task automatic hold(input int n, input logic [3:0] est, input string nm);
        for (int i = 0; i < n; i++) ev("-", est, 4'b0000, nm);
    endtask

    // Dwell in S9 from its first cycle: expiry after 20 cycles, or none without the timer
    task automatic wait_dwell(input string nm);
`ifdef MATRIX_WAIT_TIMEOUT_EN
        hold(19, 4'd9, {nm, "_hold"});
        ev("-", 4'd1, 4'b0000, {nm, "_expire"});
`else
        hold(1000, 4'd9, {nm, "_hold"});
        ev("b", 4'd1, 4'b0000, {nm, "_back"});
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        #12;
        direct_check("reset_state", 4'd0, 4'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Full compute path
        ev("c", 4'd1, 4'b0000, "idle_confirm");
        sw_mode = 3'b100;
        ev("c", 4'd8, 4'b0000, "menu_to_select");
        sw_op = 4'b0100;
        eop = 4'b0100;
        ev("c", 4'd5, 4'b0001, "select_to_compute");
        ev("-", 4'd5, 4'b0000, "compute_start_one_cycle");
        ev("cd", 4'd4, 4'b0000, "compute_done");
        ev("cd", 4'd4, 4'b0000, "stale_compute_done");
        ev("c", 4'd1, 4'b0000, "display_to_menu");

        // Invalid selections
        ev("c", 4'd8, 4'b0000, "menu_to_select2");
        sw_op = 4'b0110;
        ev("c", 4'd6, 4'b0000, "bad_op_error");
        ev("c", 4'd1, 4'b0000, "error_confirm");
        sw_mode = 3'b011;
        ev("c", 4'd6, 4'b0000, "bad_mode_error");
        ev("b", 4'd1, 4'b0000, "error_back");
        eop = 4'd0;
        ev("cb", 4'd0, 4'b0000, "back_beats_confirm");

        // Input/store and generate chains
        ev("c", 4'd1, 4'b0000, "idle_confirm2");
        sw_mode = 3'b001;
        ev("c", 4'd2, 4'b1000, "enter_input");
        ev("-", 4'd2, 4'b0000, "input_start_one_cycle");
        ev("id", 4'd7, 4'b0010, "input_done");
        ev("-", 4'd7, 4'b0000, "store_start_one_cycle");
        ev("sd", 4'd4, 4'b0000, "store_done");
        ev("b", 4'd1, 4'b0000, "display_back");
        sw_mode = 3'b010;
        ev("c", 4'd3, 4'b0100, "enter_gen");
        ev("b", 4'd3, 4'b0000, "gen_ignores_back");
        ev("gd", 4'd7, 4'b0010, "gen_done");
        ev("sd", 4'd4, 4'b0000, "store_done2");
        ev("c", 4'd1, 4'b0000, "display_confirm");

        // Timeout path with simultaneous dim_err + compute_done
        sw_mode = 3'b100;
        ev("c", 4'd8, 4'b0000, "menu_to_select3");
        sw_op = 4'b0001;
        eop = 4'b0001;
        ev("c", 4'd5, 4'b0001, "compute_T");
        ev("dc", 4'd9, 4'b0000, "dim_beats_done");
        wait_dwell("wait1");

        // Confirm on the final S9 cycle wins over expiry
        ev("c", 4'd8, 4'b0000, "menu_to_select4");
        sw_op = 4'b1000;
        eop = 4'b1000;
        ev("c", 4'd5, 4'b0001, "compute_C");
        ev("de", 4'd9, 4'b0000, "dim_err");
        hold(19, 4'd9, "wait2_hold");
        ev("c", 4'd8, 4'b0000, "confirm_beats_timeout");
        ev("b", 4'd1, 4'b0000, "select_back");

        // Back out of S9
        ev("c", 4'd8, 4'b0000, "menu_to_select5");
        sw_op = 4'b0010;
        eop = 4'b0010;
        ev("c", 4'd5, 4'b0001, "compute_A");
        ev("de", 4'd9, 4'b0000, "dim_err2");
        ev("cb", 4'd1, 4'b0000, "wait_back_beats_confirm");

        // Asynchronous reset mid-S9
        ev("c", 4'd8, 4'b0000, "menu_to_select6");
        ev("c", 4'd5, 4'b0001, "compute_A2");
        ev("de", 4'd9, 4'b0000, "dim_err3");
        hold(3, 4'd9, "wait3_hold");
        #3;
        rst_n = 1'b0;
        #1;
        eop = 4'd0;
        direct_check("async_reset", 4'd0, 4'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ev("c", 4'd1, 4'b0000, "post_reset_confirm");
        ev("c", 4'd8, 4'b0000, "post_reset_select");
        eop = 4'b0010;
        ev("c", 4'd5, 4'b0001, "post_reset_compute");
        ev("de", 4'd9, 4'b0000, "post_reset_dim");
        wait_dwell("wait4");

        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left unchecked", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
